pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/pipeline_ctrl_if.sv | 50 +++++
 rtl/perf_counter.sv | 22 ++
 rtl/pipeline_ctrl.sv | 102 ++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline hazard controller.
// Optional performance counters are enabled with PIPE_CTRL_PERF_EN.
package cpu_types_pkg;

   localparam int REG_W = 5;
   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DWAIT   = 2'd1,
      LUSTALL = 2'd2,
      HALTED  = 2'd3
   } pipectrl_state_t;

   // Register $0 is hardwired, so a load targeting it never creates a hazard.
   function automatic logic loaduse_match(input logic [REG_W-1:0] wsel,
                                          input logic [REG_W-1:0] rs,
                                          input logic [REG_W-1:0] rt);
      return (wsel != '0) && ((wsel == rs) || (wsel == rt));
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and latch-control outputs of the pipeline controller.
// Counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if;
   import cpu_types_pkg::*;

   logic             ihit;
   logic             dhit;
   logic [REG_W-1:0] ifid_rs;
   logic [REG_W-1:0] ifid_rt;
   logic             idex_dREN;
   logic [REG_W-1:0] idex_wsel;
   logic             exmem_dREN;
   logic             exmem_dWEN;
   logic             ex_redirect;
   logic             memwb_halt;

   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             memwb_en;
   logic             halted;
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
`endif

   modport master (
      output ihit, dhit, ifid_rs, ifid_rt, idex_dREN, idex_wsel,
             exmem_dREN, exmem_dWEN, ex_redirect, memwb_halt,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, memwb_en, halted
`ifdef PIPE_CTRL_PERF_EN
      , input stall_cnt, flush_cnt
`endif
   );

   modport slave (
      input  ihit, dhit, ifid_rs, ifid_rt, idex_dREN, idex_wsel,
             exmem_dREN, exmem_dWEN, ex_redirect, memwb_halt,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, memwb_en, halted
`ifdef PIPE_CTRL_PERF_EN
      , output stall_cnt, flush_cnt
`endif
   );

endinterface

// File: rtl/perf_counter.sv
// Saturating event counter: counts cycles with i_en high, sticks at all-ones.
module perf_counter
   import cpu_types_pkg::*;
#(
   parameter int WIDTH = CNT_W
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                     r_cnt <= '0;
      else if (i_en && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline latch controller: memory wait, redirect, load-use and
// fetch-wait hazards plus halt. PIPE_CTRL_PERF_EN adds stall/flush counters.
module pipeline_ctrl
   import cpu_types_pkg::*;
(
   input  logic           CLK,
   input  logic           nRST,
   pipeline_ctrl_if.slave bus
);

   pipectrl_state_t r_state, w_next;

   logic w_dwait, w_loaduse;
   logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush;
   logic w_exmem_en, w_memwb_en;

   assign w_dwait   = (bus.exmem_dREN | bus.exmem_dWEN) & ~bus.dhit;
   assign w_loaduse = bus.idex_dREN &
                      loaduse_match(bus.idex_wsel, bus.ifid_rs, bus.ifid_rt);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= RUN;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = RUN;
      w_pc_en      = 1'b1;
      w_ifid_en    = 1'b1;
      w_ifid_flush = 1'b0;
      w_idex_en    = 1'b1;
      w_idex_flush = 1'b0;
      w_exmem_en   = 1'b1;
      w_memwb_en   = 1'b1;
      if (r_state == HALTED) begin
         w_next     = HALTED;
         w_pc_en    = 1'b0;
         w_ifid_en  = 1'b0;
         w_idex_en  = 1'b0;
         w_exmem_en = 1'b0;
         w_memwb_en = 1'b0;
      end else if (w_dwait) begin
         w_next     = DWAIT;
         w_pc_en    = 1'b0;
         w_ifid_en  = 1'b0;
         w_idex_en  = 1'b0;
         w_exmem_en = 1'b0;
         w_memwb_en = 1'b0;
      end else begin
         if (bus.ex_redirect) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
         end else if (w_loaduse && r_state != LUSTALL) begin
            // One bubble per load: the LUSTALL cycle lets the dependent op go.
            w_next       = LUSTALL;
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
         end else if (!bus.ihit) begin
            w_pc_en      = 1'b0;
            w_ifid_flush = 1'b1;
         end
         // memwb_en is always high on this path, so the halt retires now.
         if (bus.memwb_halt) w_next = HALTED;
      end
   end

   assign bus.pc_en      = w_pc_en;
   assign bus.ifid_en    = w_ifid_en;
   assign bus.ifid_flush = w_ifid_flush;
   assign bus.idex_en    = w_idex_en;
   assign bus.idex_flush = w_idex_flush;
   assign bus.exmem_en   = w_exmem_en;
   assign bus.memwb_en   = w_memwb_en;
   assign bus.halted     = (r_state == HALTED);

`ifdef PIPE_CTRL_PERF_EN
   logic             w_stall_inc, w_flush_inc;
   logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

   assign w_stall_inc = ~w_pc_en & (r_state != HALTED);
   assign w_flush_inc = w_ifid_flush | w_idex_flush;

   perf_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .i_en  (w_stall_inc),
      .o_cnt (w_stall_cnt)
   );

   perf_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .i_en  (w_flush_inc),
      .o_cnt (w_flush_cnt)
   );

   assign bus.stall_cnt = w_stall_cnt;
   assign bus.flush_cnt = w_flush_cnt;
`endif

endmodule
